// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: response owner encoding,
// last-grant encoding and requester bit positions.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_own_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_sel_t;

    // Bit positions inside the 2-bit req/gnt vectors.
    localparam int REQ_IF = 0;
    localparam int REQ_D  = 1;

    // Which requester (if any) expects read data on the next cycle.
    function automatic rsp_own_t next_rsp_own(
        input logic if_gnt,
        input logic d_gnt,
        input logic d_we
    );
        rsp_own_t nxt;
        if (if_gnt) begin
            nxt = RSP_IF;
        end else if (d_gnt && !d_we) begin
            nxt = RSP_D;
        end else begin
            nxt = RSP_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a fixed-priority override that favours
// requester 1 (data). Grants are combinational; only last_gnt is stored.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    output logic [1:0] gnt
);

    gnt_sel_t   last_gnt_r;
    logic [1:0] gnt_s;

    // Grant selection from the current requests and the last winner.
    always_comb begin
        gnt_s = 2'b00;
        if (reset) begin
            gnt_s = 2'b00;
        end else begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11: begin
                    if (fixed_prio) begin
                        gnt_s = 2'b10;
                    end else if (last_gnt_r == GNT_D) begin
                        gnt_s = 2'b01;
                    end else begin
                        gnt_s = 2'b10;
                    end
                end
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner; idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= GNT_D;
        end else if (gnt_s[REQ_D]) begin
            last_gnt_r <= GNT_D;
        end else if (gnt_s[REQ_IF]) begin
            last_gnt_r <= GNT_IF;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency memory between instruction fetch
// and data load/store, returning read data with a per-requester rvalid strobe.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_fixed_prio,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [1:0] req_s;
    logic [1:0] gnt_s;
    rsp_own_t   rsp_own_r;
    rsp_own_t   rsp_own_nxt_s;

    assign req_s = {d_req, if_req};

    rr_arbiter_2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (req_s),
        .fixed_prio (cfg_fixed_prio),
        .gnt        (gnt_s)
    );

    // Per-requester grant outputs.
    always_comb begin
        if_gnt = gnt_s[REQ_IF];
        d_gnt  = gnt_s[REQ_D];
    end

    // Memory port follows the granted requester; idle port is driven to zero.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {DATA_WIDTH{1'b0}};
        case (gnt_s)
            2'b01: begin
                mem_addr = if_addr;
            end
            2'b10: begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = {ADDR_WIDTH{1'b0}};
                mem_wdata = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Next response owner: reads only, writes complete at grant.
    always_comb begin
        rsp_own_nxt_s = next_rsp_own(gnt_s[REQ_IF], gnt_s[REQ_D], d_we);
    end

    // Response owner register; reset drops any outstanding read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_own_r <= RSP_IDLE;
        end else begin
            rsp_own_r <= rsp_own_nxt_s;
        end
    end

    // rvalid is masked during reset so a response in flight never surfaces.
    always_comb begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if (reset) begin
            if_rvalid = 1'b0;
            d_rvalid  = 1'b0;
        end else begin
            case (rsp_own_r)
                RSP_IF:  if_rvalid = 1'b1;
                RSP_D:   d_rvalid  = 1'b1;
                default: begin
                    if_rvalid = 1'b0;
                    d_rvalid  = 1'b0;
                end
            endcase
        end
    end

    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
